ifu_fetch: RTL and testbench

Parametrised instruction fetch unit with its own PC register and sequential PC generation.
- Issues at most one outstanding read on a valid/ready memory request channel, then takes the response.
- Buffers fetched instructions in a small FIFO and presents them to decode on a valid/ready handshake.
- Supports redirects (branch/jump/trap) that flush all in-flight and buffered state.
- Replaces the combinational single-cycle fetch path; sits between the PC-redirect logic and decode.

---
 rtl/ifu_fetch.sv | 151 +++++++++++++++
 tb/tb_ifu_fetch.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, keeps at most one memory read in flight
// and queues returned instructions for decode in a small credit-managed FIFO.
module ifu_fetch #(
    parameter int unsigned      XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(64'h80000000),
    parameter int unsigned      MEM_W    = 64,
    parameter int unsigned      QDEPTH   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [MEM_W-1:0] mem_resp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  inst_pc,
    output logic             busy
);

    localparam int unsigned     OFF        = $clog2(MEM_W / 8);
    localparam int unsigned     PW         = $clog2(QDEPTH);
    localparam int unsigned     CW         = PW + 1;
    localparam logic [CW:0]     QDEPTH_C   = (CW + 1)'(QDEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << OFF;

    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_KILL} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     hold_inst_q, hold_inst_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     fifo_inst_q [QDEPTH];
    logic [XLEN-1:0] fifo_pc_q   [QDEPTH];

    logic [CW:0]     used;
    logic            has_credit;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [31:0]     resp_word;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    generate
        if (MEM_W == 64) begin : g_sel64
            assign resp_word = req_pc_q[2] ? mem_resp_data[MEM_W-1:32] : mem_resp_data[31:0];
        end else begin : g_sel32
            assign resp_word = mem_resp_data[31:0];
        end
    endgenerate

    // The outstanding request already owns a FIFO slot, so it counts against credit.
    assign used       = {1'b0, count_q} + {{CW{1'b0}}, (state_q == ST_WAIT)};
    assign has_credit = used < QDEPTH_C;

    assign mem_req_valid = !reset && (state_q == ST_REQ) && has_credit && !redirect_valid;
    assign mem_req_addr  = reset ? '0 : (fetch_pc_q & ALIGN_MASK);
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign inst_valid = !reset && (count_q != '0);
    assign inst       = reset ? '0 : ((count_q != '0) ? fifo_inst_q[rd_ptr_q] : hold_inst_q);
    assign inst_pc    = reset ? '0 : ((count_q != '0) ? fifo_pc_q[rd_ptr_q] : hold_pc_q);
    assign busy       = !reset && ((state_q == ST_WAIT) || (state_q == ST_KILL));

    assign push = !reset && !redirect_valid && (state_q == ST_WAIT) && mem_resp_valid;
    assign pop  = inst_valid && inst_ready;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        hold_inst_d = inst;
        hold_pc_d   = inst_pc;

        if (reset) begin
            state_d    = ST_REQ;
            fetch_pc_d = RESET_PC;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            wr_ptr_d   = rd_ptr_q;
            count_d    = '0;
            // A request still in flight must have its response swallowed.
            case (state_q)
                ST_WAIT, ST_KILL: state_d = mem_resp_valid ? ST_REQ : ST_KILL;
                default:          state_d = ST_REQ;
            endcase
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        req_pc_d = fetch_pc_q;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        fetch_pc_d = req_pc_q + XLEN'(4);
                        state_d    = ST_REQ;
                    end
                end
                ST_KILL: begin
                    if (mem_resp_valid) state_d = ST_REQ;
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        state_q     <= state_d;
        fetch_pc_q  <= fetch_pc_d;
        req_pc_q    <= req_pc_d;
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
        hold_inst_q <= hold_inst_d;
        hold_pc_q   <= hold_pc_d;
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= resp_word;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
        end
        if (!reset && push && !pop) begin
            assert (count_q < CW'(QDEPTH));
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a queued memory model with programmable latency feeds
// the 64-bit instance, a fixed 1-cycle responder feeds a 32-bit instance.
module tb_ifu_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        busy;

    logic        d32_req_valid;
    logic [63:0] d32_req_addr;
    logic        d32_resp_valid = 1'b0;
    logic [31:0] d32_resp_data = '0;
    logic        d32_inst_valid;
    logic [31:0] d32_inst;
    logic [63:0] d32_inst_pc;
    logic        d32_busy;
    logic        d32_redirect_valid = 1'b0;
    logic [63:0] d32_redirect_pc = '0;
    logic        d32_req_ready = 1'b1;
    logic        d32_inst_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } pop_t;

    typedef struct {
        logic [63:0] addr;
        int          cnt;
    } mreq_t;

    typedef struct {
        bit          irdy;
        bit          e_rv;
        logic [63:0] e_addr;
        bit          e_iv;
        logic [63:0] e_ipc;
        bit          e_busy;
    } vec_t;

    logic [63:0] hs_log[$];
    pop_t        pop_log[$];
    logic [63:0] hs32_log[$];
    pop_t        pop32_log[$];
    mreq_t       mq[$];

    logic        hs_seen = 1'b0;
    logic [63:0] hs_addr = '0;
    logic        hs32_seen = 1'b0;
    logic [63:0] hs32_addr = '0;
    int          mem_lat = 1;
    int          flush_req = 0;
    int          flush_seen = 0;

    ifu_fetch #(.XLEN(64), .RESET_PC(64'h80000000), .MEM_W(64), .QDEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .busy(busy)
    );

    ifu_fetch #(.XLEN(64), .RESET_PC(64'h80000000), .MEM_W(32), .QDEPTH(2)) dut32 (
        .clock(clock), .reset(reset),
        .redirect_valid(d32_redirect_valid), .redirect_pc(d32_redirect_pc),
        .mem_req_valid(d32_req_valid), .mem_req_ready(d32_req_ready), .mem_req_addr(d32_req_addr),
        .mem_resp_valid(d32_resp_valid), .mem_resp_data(d32_resp_data),
        .inst_valid(d32_inst_valid), .inst_ready(d32_inst_ready), .inst(d32_inst), .inst_pc(d32_inst_pc),
        .busy(d32_busy)
    );

    initial forever #5 clock = ~clock;

    // Each memory word encodes its own address so a wrong half or stale push is visible.
    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return {8'hA5, pc[23:0]};
    endfunction

    initial forever begin
        @(posedge clock);
        hs_seen   <= mem_req_valid && mem_req_ready;
        hs_addr   <= mem_req_addr;
        hs32_seen <= d32_req_valid && d32_req_ready;
        hs32_addr <= d32_req_addr;
        if (mem_req_valid && mem_req_ready) hs_log.push_back(mem_req_addr);
        if (inst_valid && inst_ready) pop_log.push_back('{inst_pc, inst});
        if (d32_req_valid && d32_req_ready) hs32_log.push_back(d32_req_addr);
        if (d32_inst_valid && d32_inst_ready) pop32_log.push_back('{d32_inst_pc, d32_inst});
    end

    initial forever begin
        @(negedge clock);
        if (hs_seen) mq.push_back('{hs_addr, mem_lat});
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (flush_req != flush_seen) begin
            mq.delete();
            flush_seen = flush_req;
        end else if (mq.size() > 0 && mq[0].cnt <= 1) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = {inst_of(mq[0].addr + 64'd4), inst_of(mq[0].addr)};
            void'(mq.pop_front());
        end
        foreach (mq[i]) mq[i].cnt = mq[i].cnt - 1;
    end

    initial forever begin
        @(negedge clock);
        d32_resp_valid = hs32_seen;
        d32_resp_data  = inst_of(hs32_addr);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk_cycle(input string tag, input bit e_rv, input logic [63:0] e_addr,
                             input bit e_iv, input logic [63:0] e_ipc, input bit e_busy);
        #1;
        chk($sformatf("%s.req_valid", tag), {63'd0, mem_req_valid}, {63'd0, e_rv});
        if (e_rv) chk($sformatf("%s.req_addr", tag), mem_req_addr, e_addr);
        chk($sformatf("%s.inst_valid", tag), {63'd0, inst_valid}, {63'd0, e_iv});
        if (e_iv) begin
            chk($sformatf("%s.inst_pc", tag), inst_pc, e_ipc);
            chk($sformatf("%s.inst", tag), {32'd0, inst}, {32'd0, inst_of(e_ipc)});
        end
        chk($sformatf("%s.busy", tag), {63'd0, busy}, {63'd0, e_busy});
    endtask

    task automatic chk_reset(input string tag);
        #1;
        chk($sformatf("%s.req_valid", tag), {63'd0, mem_req_valid}, 64'd0);
        chk($sformatf("%s.req_addr", tag), mem_req_addr, 64'd0);
        chk($sformatf("%s.inst_valid", tag), {63'd0, inst_valid}, 64'd0);
        chk($sformatf("%s.inst", tag), {32'd0, inst}, 64'd0);
        chk($sformatf("%s.inst_pc", tag), inst_pc, 64'd0);
        chk($sformatf("%s.busy", tag), {63'd0, busy}, 64'd0);
    endtask

    // Leaves the caller at the first post-reset negedge with reset low.
    task automatic do_reset();
        tick();
        reset = 1'b1;
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        mem_req_ready = 1'b1;
        mem_lat = 1;
        flush_req++;
        tick();
        tick();
        reset = 1'b0;
    endtask

    vec_t vt[7];
    int   hb;
    int   pb;

    initial begin
        vt[0] = '{1'b1, 1'b1, 64'h80000000, 1'b0, 64'h0,        1'b0};
        vt[1] = '{1'b1, 1'b0, 64'h0,        1'b0, 64'h0,        1'b1};
        vt[2] = '{1'b1, 1'b1, 64'h80000000, 1'b1, 64'h80000000, 1'b0};
        vt[3] = '{1'b1, 1'b0, 64'h0,        1'b0, 64'h0,        1'b1};
        vt[4] = '{1'b1, 1'b1, 64'h80000008, 1'b1, 64'h80000004, 1'b0};
        vt[5] = '{1'b1, 1'b0, 64'h0,        1'b0, 64'h0,        1'b1};
        vt[6] = '{1'b1, 1'b1, 64'h80000008, 1'b1, 64'h80000008, 1'b0};

        tick();
        tick();
        chk_reset("reset");

        // Free-running fetch from reset with a 1-cycle memory
        for (int i = 0; i < 7; i++) begin
            tick();
            reset = 1'b0;
            inst_ready = vt[i].irdy;
            chk_cycle($sformatf("run%0d", i), vt[i].e_rv, vt[i].e_addr, vt[i].e_iv, vt[i].e_ipc, vt[i].e_busy);
        end

        chk("m32.hs_count", 64'(hs32_log.size() >= 2), 64'd1);
        chk("m32.pop_count", 64'(pop32_log.size() >= 2), 64'd1);
        if (hs32_log.size() >= 2) begin
            chk("m32.addr0", hs32_log[0], 64'h80000000);
            chk("m32.addr1", hs32_log[1], 64'h80000004);
        end
        if (pop32_log.size() >= 2) begin
            chk("m32.pc0", pop32_log[0].pc, 64'h80000000);
            chk("m32.inst0", {32'd0, pop32_log[0].ins}, {32'd0, inst_of(64'h80000000)});
            chk("m32.pc1", pop32_log[1].pc, 64'h80000004);
            chk("m32.inst1", {32'd0, pop32_log[1].ins}, {32'd0, inst_of(64'h80000004)});
        end

        // Backpressure: two instructions buffered, no third request
        do_reset();
        inst_ready = 1'b0;
        hb = hs_log.size();
        pb = pop_log.size();
        chk_cycle("bp0", 1'b1, 64'h80000000, 1'b0, 64'h0, 1'b0);
        repeat (9) tick();
        chk_cycle("bp_stall", 1'b0, 64'h0, 1'b1, 64'h80000000, 1'b0);
        chk("bp.req_count", 64'(hs_log.size() - hb), 64'd2);
        chk("bp.pop_count", 64'(pop_log.size() - pb), 64'd0);
        tick();
        inst_ready = 1'b1;
        repeat (7) tick();
        #1;
        chk("bp.drained", 64'(pop_log.size() - pb >= 3), 64'd1);
        if (pop_log.size() - pb >= 3) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("bp.pop%0d_pc", k), pop_log[pb + k].pc, 64'h80000000 + 64'(4 * k));
                chk($sformatf("bp.pop%0d_inst", k), {32'd0, pop_log[pb + k].ins},
                    {32'd0, inst_of(64'h80000000 + 64'(4 * k))});
            end
        end

        // Redirect while waiting on a slow response
        do_reset();
        mem_lat = 3;
        hb = hs_log.size();
        chk_cycle("rw0", 1'b1, 64'h80000000, 1'b0, 64'h0, 1'b0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h80001006;
        chk_cycle("rw1", 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        redirect_valid = 1'b0;
        chk_cycle("rw2", 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        mem_lat = 1;
        chk_cycle("rw3", 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        chk_cycle("rw4", 1'b1, 64'h80001000, 1'b0, 64'h0, 1'b0);
        tick();
        chk_cycle("rw5", 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        chk_cycle("rw6", 1'b1, 64'h80001008, 1'b1, 64'h80001004, 1'b0);
        chk("rw.req_count", 64'(hs_log.size() - hb), 64'd2);
        if (hs_log.size() - hb >= 2) chk("rw.req1_addr", hs_log[hb + 1], 64'h80001000);

        // Redirect coinciding with a response and a decode handshake
        do_reset();
        inst_ready = 1'b0;
        pb = pop_log.size();
        chk_cycle("rr0", 1'b1, 64'h80000000, 1'b0, 64'h0, 1'b0);
        tick();
        chk_cycle("rr1", 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        chk_cycle("rr2", 1'b1, 64'h80000000, 1'b1, 64'h80000000, 1'b0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h80002000;
        inst_ready = 1'b1;
        chk_cycle("rr3", 1'b0, 64'h0, 1'b1, 64'h80000000, 1'b1);
        tick();
        redirect_valid = 1'b0;
        chk_cycle("rr4", 1'b1, 64'h80002000, 1'b0, 64'h0, 1'b0);
        tick();
        chk_cycle("rr5", 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        chk_cycle("rr6", 1'b1, 64'h80002000, 1'b1, 64'h80002000, 1'b0);
        chk("rr.pop_count", 64'(pop_log.size() - pb), 64'd1);

        // Memory not ready: request held stable
        do_reset();
        mem_req_ready = 1'b0;
        hb = hs_log.size();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            chk_cycle($sformatf("nr%0d", k), 1'b1, 64'h80000000, 1'b0, 64'h0, 1'b0);
        end
        tick();
        mem_req_ready = 1'b1;
        chk_cycle("nr5", 1'b1, 64'h80000000, 1'b0, 64'h0, 1'b0);
        tick();
        chk_cycle("nr6", 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        chk_cycle("nr7", 1'b1, 64'h80000000, 1'b1, 64'h80000000, 1'b0);
        chk("nr.req_count", 64'(hs_log.size() - hb), 64'd1);

        // Reset while a slow response is outstanding
        do_reset();
        chk_cycle("rs0", 1'b1, 64'h80000000, 1'b0, 64'h0, 1'b0);
        tick();
        tick();
        chk_cycle("rs2", 1'b1, 64'h80000000, 1'b1, 64'h80000000, 1'b0);
        tick();
        tick();
        mem_lat = 3;
        chk_cycle("rs4", 1'b1, 64'h80000008, 1'b1, 64'h80000004, 1'b0);
        tick();
        reset = 1'b1;
        chk_reset("rs5");
        tick();
        mem_lat = 1;
        chk_reset("rs6");
        tick();
        reset = 1'b0;
        chk_cycle("rs7", 1'b1, 64'h80000000, 1'b0, 64'h0, 1'b0);
        tick();
        chk_cycle("rs8", 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        chk_cycle("rs9", 1'b1, 64'h80000000, 1'b1, 64'h80000000, 1'b0);
        tick();
        chk_cycle("rs10", 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        chk_cycle("rs11", 1'b1, 64'h80000008, 1'b1, 64'h80000004, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
